vga_fill: RTL and testbench

Rectangle-fill engine acting as an AXI4-Lite write initiator toward the VGA framebuffer write port. It accepts one fill command (origin, size, 12-bit colour) and issues one single-beat write per pixel, in raster order, into the 320x240 framebuffer (640x480 at 2x scale). Together with the framebuffer it is the hardware path the CPU uses to clear the screen and draw blocks without per-pixel software stores.

---
 rtl/vga_fill.sv | 188 ++++++++++++++++++
 tb/tb_vga_fill.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fill.sv
// rtl/vga_fill.sv - rectangle-fill engine issuing one AXI4-Lite write per pixel
//
// Accepts a fill command (origin, size, 12-bit colour), clips it to the
// framebuffer, and walks the clipped rectangle in raster order. Each pixel is
// sent as one single-beat write, and only one write is outstanding at a time.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_x0, cmd_y0     rectangle origin (column, row)
//   cmd_w, cmd_h       rectangle size in pixels
//   cmd_color          pixel value {blue, green, red}
//   aw*                write address channel (initiator side)
//   w*                 write data channel (initiator side)
//   b*                 write response channel (initiator side)
//   done               one-cycle pulse when a command completes
//   err                sticky non-OKAY response flag for current/last command
module vga_fill #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int BASE_ADDR  = 0,
  parameter int FB_W       = 320,
  parameter int FB_H       = 240
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [8:0]            cmd_x0,
  input  logic [7:0]            cmd_y0,
  input  logic [8:0]            cmd_w,
  input  logic [7:0]            cmd_h,
  input  logic [11:0]           cmd_color,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t      state;
  logic [8:0]  x0_q;
  logic [8:0]  x_q;
  logic [7:0]  y_q;
  logic [9:0]  x_end_q;
  logic [8:0]  y_end_q;

  // Command-side clipping. Sums are one bit wider than the operands so a
  // rectangle that runs off the right/bottom edge clips instead of wrapping.
  logic [9:0]  cmd_x_sum;
  logic [8:0]  cmd_y_sum;
  logic [9:0]  cmd_x_end;
  logic [8:0]  cmd_y_end;
  logic        cmd_empty;

  // Raster walk: next pixel position and whether the current one is the last.
  logic [9:0]  x_inc;
  logic        row_end;
  logic        last_pix;
  logic [8:0]  x_nxt;
  logic [7:0]  y_nxt;

  // A channel counts as finished once its valid has dropped or is being
  // accepted this cycle; the two channels may complete in either order.
  logic        aw_ok;
  logic        w_ok;

  assign awprot = 3'b000;
  assign wstrb  = '1;

  always_comb begin
    cmd_x_sum = {1'b0, cmd_x0} + {1'b0, cmd_w};
    cmd_y_sum = {1'b0, cmd_y0} + {1'b0, cmd_h};
    cmd_x_end = (cmd_x_sum > 10'(FB_W)) ? 10'(FB_W) : cmd_x_sum;
    cmd_y_end = (cmd_y_sum > 9'(FB_H)) ? 9'(FB_H) : cmd_y_sum;
    cmd_empty = (cmd_w == 9'd0) || (cmd_h == 8'd0) ||
                ({1'b0, cmd_x0} >= 10'(FB_W)) || ({1'b0, cmd_y0} >= 9'(FB_H));
  end

  always_comb begin
    x_inc    = {1'b0, x_q} + 10'd1;
    row_end  = (x_inc == x_end_q);
    last_pix = row_end && (({1'b0, y_q} + 9'd1) == y_end_q);
    x_nxt    = row_end ? x0_q : x_inc[8:0];
    y_nxt    = row_end ? (y_q + 8'd1) : y_q;
    aw_ok    = !awvalid || awready;
    w_ok     = !wvalid || wready;
  end

  // Pixel index fits in 17 bits (239*320+319 < 2^17); the byte address is
  // truncated to the bus width after the base is added.
  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [8:0] px,
                                                     input logic [7:0] py);
    logic [16:0] idx;
    idx = 17'(py) * 17'(FB_W) + 17'(px);
    return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({idx, 2'b00});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      x0_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            err   <= 1'b0;
            wdata <= DATA_WIDTH'(cmd_color);
            if (cmd_empty) begin
              // Nothing to draw: complete immediately and stay ready.
              done <= 1'b1;
            end else begin
              x0_q      <= cmd_x0;
              x_q       <= cmd_x0;
              y_q       <= cmd_y0;
              x_end_q   <= cmd_x_end;
              y_end_q   <= cmd_y_end;
              awaddr    <= pix_addr(cmd_x0, cmd_y0);
              awvalid   <= 1'b1;
              wvalid    <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            state  <= S_RESP;
          end
        end

        S_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) err <= 1'b1;
            if (last_pix) begin
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              x_q     <= x_nxt;
              y_q     <= y_nxt;
              awaddr  <= pix_addr(x_nxt, y_nxt);
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_ISSUE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fill.sv
// tb/tb_vga_fill.sv - self-checking bench for vga_fill
module tb_vga_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [11:0] cmd_color;
  logic [23:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Command queued behind a busy engine (used by the chained test).
  int          nxt_x0, nxt_y0, nxt_w, nxt_h;
  logic [11:0] nxt_col;

  vga_fill dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .awaddr    (awaddr),
    .awprot    (awprot),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .done      (done),
    .err       (err)
  );

  always #10 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one command and act as the write slave. Expected pixel order comes
  // from plain clipping arithmetic over the rectangle.
  //   awd/wd/bd : ready / response delays in cycles (-1 = random per pixel)
  //   resp_mode : -1 all OKAY, k>=0 SLVERR on pixel k, -2 random responses
  //   abort_at  : assert reset when pixel abort_at is being issued (-1 none)
  //   pre       : command was already accepted at the previous done cycle
  //   chain     : keep nxt_* command presented while this one runs
  task automatic do_fill(input int x0, input int y0, input int w, input int h,
                         input logic [11:0] col, input int awd, input int wd,
                         input int bd, input int resp_mode, input int abort_at,
                         input bit pre, input bit chain);
    int unsigned q[$];
    int  xe, ye;
    bit  bad;
    bit  aw_hs, w_hs;
    int  c, a_d, w_d, b_d;
    logic [1:0] br;

    xe = (x0 + w > 320) ? 320 : x0 + w;
    ye = (y0 + h > 240) ? 240 : y0 + h;
    for (int yy = y0; yy < ye; yy++)
      for (int xx = x0; xx < xe; xx++)
        q.push_back(yy * 320 + xx);

    if (!pre) begin
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_x0    = 9'(x0);
      cmd_y0    = 8'(y0);
      cmd_w     = 9'(w);
      cmd_h     = 8'(h);
      cmd_color = col;
      cmd_valid = 1'b1;
    end
    @(negedge clk);
    if (chain) begin
      cmd_x0    = 9'(nxt_x0);
      cmd_y0    = 8'(nxt_y0);
      cmd_w     = 9'(nxt_w);
      cmd_h     = 8'(nxt_h);
      cmd_color = nxt_col;
    end else begin
      cmd_valid = 1'b0;
    end
    chk("err_clear_on_accept", err, 0);
    bad = 1'b0;

    if (q.size() == 0) begin
      chk("empty_done", done, 1);
      chk("empty_no_aw", awvalid, 0);
      chk("empty_ready", cmd_ready, 1);
      @(negedge clk);
      chk("empty_done_low", done, 0);
      chk("empty_no_aw2", awvalid, 0);
      return;
    end

    chk("busy_not_ready", cmd_ready, 0);

    for (int k = 0; k < q.size(); k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_awvalid", awvalid, 0);
        chk("abort_wvalid", wvalid, 0);
        chk("abort_bready", bready, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_no_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done2", done, 0);
        chk("abort_idle", awvalid, 0);
        return;
      end

      chk("aw_rise", awvalid, 1);
      chk("w_rise", wvalid, 1);
      chk("done_low_busy", done, 0);
      a_d = (awd < 0) ? int'($urandom_range(0, 4)) : awd;
      w_d = (wd < 0) ? int'($urandom_range(0, 4)) : wd;
      aw_hs = 1'b0;
      w_hs  = 1'b0;
      c     = 0;
      while (!(aw_hs && w_hs)) begin
        if (c > 60) begin
          checks++;
          errors++;
          $error("FAIL hs_timeout: observed=%0d cycles expected=handshake", c);
          break;
        end
        if (!aw_hs) begin
          chk("awvalid_hold", awvalid, 1);
          chk("awaddr", 32'(awaddr), q[k] * 4);
        end else begin
          chk("awvalid_drop", awvalid, 0);
        end
        if (!w_hs) begin
          chk("wvalid_hold", wvalid, 1);
          chk("wdata", wdata, {20'd0, col});
          chk("wstrb", 32'(wstrb), 32'hF);
        end else begin
          chk("wvalid_drop", wvalid, 0);
        end
        chk("bready_in_issue", bready, 0);
        awready = !aw_hs && (c >= a_d);
        wready  = !w_hs && (c >= w_d);
        if (awready) aw_hs = 1'b1;
        if (wready)  w_hs  = 1'b1;
        @(negedge clk);
        c++;
      end
      awready = 1'b0;
      wready  = 1'b0;

      b_d = (bd < 0) ? int'($urandom_range(0, 4)) : bd;
      for (int i = 0; i < b_d; i++) begin
        chk("bready_wait", bready, 1);
        chk("no_aw_in_resp", awvalid, 0);
        chk("no_w_in_resp", wvalid, 0);
        @(negedge clk);
      end
      chk("bready_hs", bready, 1);
      if (resp_mode == -2)
        br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else
        br = (k == resp_mode) ? 2'b10 : 2'b00;
      if (br != 2'b00) bad = 1'b1;
      bvalid = 1'b1;
      bresp  = br;
      @(negedge clk);
      bvalid = 1'b0;
      bresp  = 2'b00;
      chk("bready_after_b", bready, 0);
    end

    chk("done_pulse", done, 1);
    chk("done_ready", cmd_ready, 1);
    chk("done_err", err, bad);
    chk("done_no_aw", awvalid, 0);
    if (!chain) begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("err_sticky", err, bad);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_awaddr", 32'(awaddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", 32'(wstrb), 32'hF);
    chk("rst_awprot", 32'(awprot), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single pixel, zero-wait slave: address 965*4 = 0xF14.
    do_fill(5, 3, 1, 1, 12'hABC, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    // Right-edge clip: 3x2 at (318,0) becomes 318,319,638,639.
    do_fill(318, 0, 3, 2, 12'h123, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    // Skewed backpressure: W accepted 4 cycles before AW, B late by 5.
    do_fill(10, 10, 2, 1, 12'h5A5, 4, 0, 5, -1, -1, 1'b0, 1'b0);
    // SLVERR on the second of four pixels; fill continues, err sticks.
    do_fill(20, 5, 2, 2, 12'hF0F, 0, 0, 0, 1, -1, 1'b0, 1'b0);
    // Next accept clears err.
    do_fill(0, 0, 1, 1, 12'h001, 1, 2, 1, -1, -1, 1'b0, 1'b0);
    // Degenerate commands.
    do_fill(7, 7, 0, 3, 12'h777, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    do_fill(320, 10, 4, 4, 12'h888, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    do_fill(3, 240, 2, 2, 12'h999, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    do_fill(3, 4, 2, 0, 12'h999, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    // Bottom-right corner clip.
    do_fill(319, 239, 5, 5, 12'hEEE, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    // Command held while busy is accepted in the done cycle.
    nxt_x0 = 100; nxt_y0 = 100; nxt_w = 2; nxt_h = 1; nxt_col = 12'hC3C;
    do_fill(50, 50, 2, 1, 12'h3C3, 1, 1, 2, -1, -1, 1'b0, 1'b1);
    do_fill(100, 100, 2, 1, 12'hC3C, 0, 0, 0, -1, -1, 1'b1, 1'b0);
    // Reset while issuing pixel 2 of 10.
    do_fill(0, 20, 10, 1, 12'h456, 0, 0, 0, -1, 2, 1'b0, 1'b0);
    // Engine usable again after the abort.
    do_fill(30, 30, 1, 2, 12'h654, 0, 0, 0, -1, -1, 1'b0, 1'b0);

    // Randomized commands, delays and responses.
    for (int n = 0; n < 12; n++) begin
      do_fill(int'($urandom_range(0, 325)), int'($urandom_range(0, 245)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
              12'($urandom), -1, -1, -1, -2, -1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
